rptr_empty_sync: RTL

Read-side pointer and empty-flag logic for the asynchronous FIFO, the counterpart of the write-pointer/full block. It owns the read pointer, brings the write-domain Gray pointer into the read clock domain, and produces registered empty, almost-empty, occupancy and underflow indications. It drives the dual-port memory read address and returns its Gray read pointer to the write domain.

---
 rtl/rptr_empty_sync.sv | 70 +++++++
 1 files changed

// File: rtl/rptr_empty_sync.sv
// Read-side pointer, write-pointer synchronizer and empty/occupancy flags
// for the asynchronous FIFO.
module rptr_empty_sync #(
    parameter int n               = 4,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic         clk,
    input  logic         rrst,
    input  logic         rinc,
    input  logic [n:0]   w_gptr,
    output logic [n-1:0] r_bptr,
    output logic [n:0]   r_gptr,
    output logic         rempty,
    output logic         ralmost_empty,
    output logic [n:0]   rcount,
    output logic         runderflow
);

    localparam logic [n:0] AE_TH = ALMOST_EMPTY_TH[n:0];

    function automatic logic [n:0] gray2bin(input logic [n:0] g);
        logic [n:0] b;
        b[n] = g[n];
        for (int i = n - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [n:0] rbin;
    logic [n:0] wq1;
    logic [n:0] wq2;
    logic       accept;
    logic [n:0] rbin_next;
    logic [n:0] rgray_next;
    logic [n:0] wbin;
    logic [n:0] count_next;

    assign accept     = rinc && !rempty;
    assign rbin_next  = rbin + {{n{1'b0}}, accept};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    // Occupancy uses the already-synchronized pointer, so writes show up late.
    assign wbin       = gray2bin(wq2);
    assign count_next = wbin - rbin_next;

    assign r_bptr = rbin[n-1:0];

    always_ff @(posedge clk) begin
        if (rrst) begin
            rbin          <= '0;
            r_gptr        <= '0;
            wq1           <= '0;
            wq2           <= '0;
            rcount        <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            runderflow    <= 1'b0;
        end else begin
            wq1           <= w_gptr;
            wq2           <= wq1;
            rbin          <= rbin_next;
            r_gptr        <= rgray_next;
            rempty        <= (rgray_next == wq2);
            rcount        <= count_next;
            ralmost_empty <= (count_next <= AE_TH);
            runderflow    <= rinc && rempty;
        end
    end

endmodule
